// File: rtl/switch_pkg.sv
// Shared definitions for the switch ingress path: framing bytes, CRC constants,
// pointer-word layout and the receive-writer state encoding.
package switch_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  // Pointer word: {rsvd, portmap, length}
  localparam int unsigned PTR_W        = 16;
  localparam int unsigned PTR_LEN_W    = 11;
  localparam int unsigned PTR_PORT_W   = 4;
  localparam int unsigned PTR_LEN_OFS  = 0;
  localparam int unsigned PTR_PORT_OFS = PTR_LEN_OFS + PTR_LEN_W;

  // Bytes held back so the FCS never reaches the data FIFO
  localparam int unsigned DLY_BYTES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DROP     = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic                  rsvd;
    logic [PTR_PORT_W-1:0] portmap;
    logic [PTR_LEN_W-1:0]  len;
  } ptr_word_t;

  // MSB-first register, data bits fed LSB first (wire order); the good-frame
  // residue in this orientation is CRC_RESIDUE.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                input logic [7:0]  d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator.
// Ports: clk, rstn (async active-low), init_i (load CRC_INIT), en_i (absorb
// data_i), data_i byte, crc_o current register value.
module crc32_d8
  import switch_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // init has priority over enable
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_d8_next(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/port_rx_writer.sv
// Ingress receive writer: strips preamble/SFD, writes frame bytes (minus FCS)
// into the data FIFO, checks CRC and length, then commits with a pointer word
// or aborts.
// Ports: clk, rstn; rx_dv/rx_data receive stream; sfifo_* data FIFO write side
// (wr, din, commit, abort, free); ptr_sfifo_* pointer FIFO (wr, din, full);
// rx_good/rx_drop per-frame status pulses.
module port_rx_writer
  import switch_pkg::*;
#(
  parameter logic [3:0]  PORTMAP = 4'b0001,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_dv,
  input  logic [7:0]       rx_data,
  output logic             sfifo_wr,
  output logic [7:0]       sfifo_din,
  output logic             sfifo_commit,
  output logic             sfifo_abort,
  input  logic [11:0]      sfifo_free,
  output logic             ptr_sfifo_wr,
  output logic [PTR_W-1:0] ptr_sfifo_din,
  input  logic             ptr_sfifo_full,
  output logic             rx_good,
  output logic             rx_drop
);

  rx_state_e                   state_q, state_d;
  logic [DLY_BYTES-1:0][7:0]   dly_q, dly_d;
  logic [2:0]                  fill_q, fill_d;
  logic [PTR_LEN_W-1:0]        len_q, len_d;
  logic                        wr_q, wr_d;
  logic [7:0]                  din_q, din_d;
  logic                        commit_q, commit_d;
  logic                        abort_q, abort_d;
  logic                        ptr_wr_q, ptr_wr_d;
  ptr_word_t                   ptr_din_q, ptr_din_d;
  logic                        good_q, good_d;
  logic                        drop_q, drop_d;

  logic                        crc_init_c;
  logic                        crc_en_c;
  logic [31:0]                 crc_c;
  logic                        admit_c;

  crc32_d8 u_crc (
    .clk    (clk),
    .rstn   (rstn),
    .init_i (crc_init_c),
    .en_i   (crc_en_c),
    .data_i (rx_data),
    .crc_o  (crc_c)
  );

  // Room for a maximum-size frame and a free pointer slot at SFD time
  assign admit_c = (sfifo_free >= 12'(MAX_LEN)) && !ptr_sfifo_full;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    fill_d     = fill_q;
    len_d      = len_q;
    wr_d       = 1'b0;
    din_d      = din_q;
    commit_d   = 1'b0;
    abort_d    = 1'b0;
    ptr_wr_d   = 1'b0;
    ptr_din_d  = ptr_din_q;
    good_d     = 1'b0;
    drop_d     = 1'b0;
    crc_init_c = 1'b0;
    crc_en_c   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (rx_data == PREAMBLE_BYTE) begin
          state_d = ST_PREAMBLE;
        end else if (rx_data == SFD_BYTE) begin
          if (admit_c) begin
            state_d    = ST_DATA;
            crc_init_c = 1'b1;
            len_d      = '0;
            fill_d     = '0;
          end else begin
            state_d = ST_DROP;
            drop_d  = 1'b1;
          end
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (!rx_dv) begin
          state_d = ST_CHECK;
          fill_d  = '0;
        end else begin
          crc_en_c = 1'b1;
          dly_d    = {dly_q[DLY_BYTES-2:0], rx_data};
          if (fill_q == 3'(DLY_BYTES)) begin
            // Oldest byte leaves the delay line; refuse to exceed MAX_LEN
            if (len_q == PTR_LEN_W'(MAX_LEN)) begin
              abort_d = 1'b1;
              drop_d  = 1'b1;
              state_d = ST_DROP;
            end else begin
              wr_d  = 1'b1;
              din_d = dly_q[DLY_BYTES-1];
              len_d = len_q + PTR_LEN_W'(1);
            end
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
      end

      ST_CHECK: begin
        if ((crc_c == CRC_RESIDUE) && (len_q >= PTR_LEN_W'(MIN_LEN))) begin
          commit_d          = 1'b1;
          ptr_wr_d          = 1'b1;
          good_d            = 1'b1;
          ptr_din_d.rsvd    = 1'b0;
          ptr_din_d.portmap = PORTMAP;
          ptr_din_d.len     = len_q;
        end else begin
          abort_d = 1'b1;
          drop_d  = 1'b1;
        end
        // Allows a next frame after a single idle cycle
        state_d = (rx_dv && (rx_data == PREAMBLE_BYTE)) ? ST_PREAMBLE : ST_IDLE;
      end

      ST_DROP: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      fill_q    <= '0;
      len_q     <= '0;
      wr_q      <= 1'b0;
      din_q     <= '0;
      commit_q  <= 1'b0;
      abort_q   <= 1'b0;
      ptr_wr_q  <= 1'b0;
      ptr_din_q <= '0;
      good_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      wr_q      <= wr_d;
      din_q     <= din_d;
      commit_q  <= commit_d;
      abort_q   <= abort_d;
      ptr_wr_q  <= ptr_wr_d;
      ptr_din_q <= ptr_din_d;
      good_q    <= good_d;
      drop_q    <= drop_d;
    end
  end

  assign sfifo_wr      = wr_q;
  assign sfifo_din     = din_q;
  assign sfifo_commit  = commit_q;
  assign sfifo_abort   = abort_q;
  assign ptr_sfifo_wr  = ptr_wr_q;
  assign ptr_sfifo_din = ptr_din_q;
  assign rx_good       = good_q;
  assign rx_drop       = drop_q;

endmodule

// File: tb/tb_port_rx_writer.sv
// Self-checking bench for port_rx_writer: table of frame scenarios plus
// hand-written back-to-back, preamble/garbage and mid-frame reset sequences.
module tb_port_rx_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        sfifo_wr;
  logic [7:0]  sfifo_din;
  logic        sfifo_commit;
  logic        sfifo_abort;
  logic [11:0] sfifo_free = 12'd2047;
  logic        ptr_sfifo_wr;
  logic [15:0] ptr_sfifo_din;
  logic        ptr_sfifo_full = 1'b0;
  logic        rx_good;
  logic        rx_drop;

  port_rx_writer dut (
    .clk            (clk),
    .rstn           (rstn),
    .rx_dv          (rx_dv),
    .rx_data        (rx_data),
    .sfifo_wr       (sfifo_wr),
    .sfifo_din      (sfifo_din),
    .sfifo_commit   (sfifo_commit),
    .sfifo_abort    (sfifo_abort),
    .sfifo_free     (sfifo_free),
    .ptr_sfifo_wr   (ptr_sfifo_wr),
    .ptr_sfifo_din  (ptr_sfifo_din),
    .ptr_sfifo_full (ptr_sfifo_full),
    .rx_good        (rx_good),
    .rx_drop        (rx_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          wr_cnt, data_err, n_commit, n_abort, n_good, n_drop, n_ptr, n_viol;
  int          pulse_cyc;
  logic [15:0] last_ptr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sfifo_wr) begin
      if (wr_cnt >= exp_q.size()) data_err++;
      else if (sfifo_din !== exp_q[wr_cnt]) data_err++;
      wr_cnt++;
    end
    if (sfifo_commit) n_commit++;
    if (sfifo_abort)  n_abort++;
    if (rx_good)      n_good++;
    if (rx_drop)      n_drop++;
    if (ptr_sfifo_wr) begin
      n_ptr++;
      last_ptr = ptr_sfifo_din;
    end
    if (sfifo_commit && sfifo_abort) n_viol++;
    if (ptr_sfifo_wr && !sfifo_commit) n_viol++;
    if (sfifo_commit || sfifo_abort || rx_drop) pulse_cyc = cyc;
  end

  task automatic clear_counts();
    wr_cnt = 0; data_err = 0; n_commit = 0; n_abort = 0; n_good = 0;
    n_drop = 0; n_ptr = 0; n_viol = 0; pulse_cyc = -1; last_ptr = 16'h0;
    exp_q.delete();
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_data = b;
  endtask

  // Drops rx_dv; end_cyc is the monitor cycle index at which rx_dv went low
  task automatic drive_idle(input int n, output int end_cyc);
    end_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) end_cyc = cyc;
      rx_dv   = 1'b0;
      rx_data = 8'h00;
    end
  endtask

  // Reflected (LSB-first) CRC-32 reference
  function automatic logic [31:0] ref_crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Preamble, SFD, payload, FCS; expected payload pushed to exp_q
  task automatic send_frame(input int len, input int seed, input bit bad_fcs,
                            output int sfd_cyc);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    sfd_cyc = cyc;
    for (int i = 0; i < len; i++) begin
      b = 8'(i * 29 + seed * 11 + 3);
      exp_q.push_back(b);
      crc = ref_crc_step(crc, b);
      drive_byte(b);
    end
    fcs = ~crc;
    if (bad_fcs) fcs[11] = ~fcs[11];
    for (int i = 0; i < 4; i++) begin
      b = fcs[7:0];
      drive_byte(b);
      fcs = fcs >> 8;
    end
  endtask

  typedef struct {
    int          len;
    bit          bad_fcs;
    logic [11:0] free;
    bit          full;
    int          exp_wr;
    int          exp_commit;
    int          exp_abort;
    int          exp_good;
    int          exp_drop;
    logic [15:0] exp_ptr;
    int          timing;   // 0 none, 1 end+2, 2 sfd+1, 3 end+0
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int sfd_c, end_c, dummy;
    vecs[0] = '{60,   0, 12'd2047, 0, 60,   1, 0, 1, 0, 16'h083C, 1};
    vecs[1] = '{60,   1, 12'd2047, 0, 60,   0, 1, 0, 1, 16'h0000, 1};
    vecs[2] = '{60,   0, 12'd1000, 0, 0,    0, 0, 0, 1, 16'h0000, 2};
    vecs[3] = '{60,   0, 12'd2047, 1, 0,    0, 0, 0, 1, 16'h0000, 2};
    vecs[4] = '{59,   0, 12'd2047, 0, 59,   0, 1, 0, 1, 16'h0000, 1};
    vecs[5] = '{64,   0, 12'd1514, 0, 64,   1, 0, 1, 0, 16'h0840, 1};
    vecs[6] = '{1514, 0, 12'd2047, 0, 1514, 1, 0, 1, 0, 16'h0DEA, 1};
    vecs[7] = '{1515, 0, 12'd2047, 0, 1514, 0, 1, 0, 1, 16'h0000, 3};
    vecs[8] = '{60,   0, 12'd1513, 0, 0,    0, 0, 0, 1, 16'h0000, 2};

    clear_counts();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sfifo_wr",      sfifo_wr,      0);
    check("rst_sfifo_din",     sfifo_din,     0);
    check("rst_sfifo_commit",  sfifo_commit,  0);
    check("rst_sfifo_abort",   sfifo_abort,   0);
    check("rst_ptr_sfifo_wr",  ptr_sfifo_wr,  0);
    check("rst_ptr_sfifo_din", ptr_sfifo_din, 0);
    check("rst_rx_good",       rx_good,       0);
    check("rst_rx_drop",       rx_drop,       0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      #1 clear_counts();
      sfifo_free     = vecs[v].free;
      ptr_sfifo_full = vecs[v].full;
      send_frame(vecs[v].len, v, vecs[v].bad_fcs, sfd_c);
      drive_idle(4, end_c);
      check($sformatf("v%0d_writes", v), wr_cnt,   vecs[v].exp_wr);
      check($sformatf("v%0d_order", v),  data_err, 0);
      check($sformatf("v%0d_commit", v), n_commit, vecs[v].exp_commit);
      check($sformatf("v%0d_abort", v),  n_abort,  vecs[v].exp_abort);
      check($sformatf("v%0d_good", v),   n_good,   vecs[v].exp_good);
      check($sformatf("v%0d_drop", v),   n_drop,   vecs[v].exp_drop);
      check($sformatf("v%0d_ptr_wr", v), n_ptr,    vecs[v].exp_commit);
      check($sformatf("v%0d_viol", v),   n_viol,   0);
      if (vecs[v].exp_commit != 0)
        check($sformatf("v%0d_ptr_word", v), last_ptr, vecs[v].exp_ptr);
      if (vecs[v].timing == 1) check($sformatf("v%0d_pulse_cyc", v), pulse_cyc, end_c + 2);
      if (vecs[v].timing == 2) check($sformatf("v%0d_pulse_cyc", v), pulse_cyc, sfd_c + 1);
      if (vecs[v].timing == 3) check($sformatf("v%0d_pulse_cyc", v), pulse_cyc, end_c);
    end
    sfifo_free     = 12'd2047;
    ptr_sfifo_full = 1'b0;

    // Back-to-back good frames with a single idle cycle
    #1 clear_counts();
    send_frame(60, 20, 0, sfd_c);
    drive_idle(1, end_c);
    send_frame(70, 21, 0, sfd_c);
    drive_idle(4, end_c);
    check("b2b_writes", wr_cnt,   130);
    check("b2b_order",  data_err, 0);
    check("b2b_commit", n_commit, 2);
    check("b2b_ptr_wr", n_ptr,    2);
    check("b2b_good",   n_good,   2);
    check("b2b_abort",  n_abort,  0);
    check("b2b_last_ptr", last_ptr, 16'h0846);
    check("b2b_pulse_cyc", pulse_cyc, end_c + 2);

    // Preamble cut short, then a frame starting with a non-preamble byte
    #1 clear_counts();
    for (int i = 0; i < 3; i++) drive_byte(8'h55);
    drive_idle(1, dummy);
    drive_byte(8'h12);
    drive_byte(8'hD5);
    for (int i = 0; i < 10; i++) drive_byte(8'(i + 8'h30));
    drive_idle(3, dummy);
    check("junk_writes", wr_cnt, 0);
    check("junk_pulses", n_commit + n_abort + n_good + n_drop + n_ptr, 0);

    // Reset mid-DATA with rx_dv held high
    #1 clear_counts();
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < 40; i++) begin
      drive_byte(8'h3C);
      if (i == 20) begin
        rstn = 1'b0;
        #1 clear_counts();
        check("midrst_wr_low", sfifo_wr, 0);
      end
      if (i == 22) rstn = 1'b1;
    end
    for (int i = 0; i < 4; i++) drive_byte(8'hA7);
    drive_idle(3, dummy);
    check("midrst_writes", wr_cnt, 0);
    check("midrst_pulses", n_commit + n_abort + n_good + n_drop + n_ptr, 0);
    send_frame(60, 30, 0, sfd_c);
    drive_idle(4, end_c);
    check("postrst_writes", wr_cnt,   60);
    check("postrst_order",  data_err, 0);
    check("postrst_commit", n_commit, 1);
    check("postrst_ptr",    last_ptr, 16'h083C);
    check("postrst_abort",  n_abort,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_rx_writer.md
PORT_RX_WRITER -- requirements
Module: port_rx_writer

Interface
REQ-001 SHALL have parameter PORTMAP, default 4'b0001, one-hot ingress port tag written into pointer words.
REQ-002 SHALL have parameter MIN_LEN, default 60, minimum accepted frame bytes excluding FCS.
REQ-003 SHALL have parameter MAX_LEN, default 1514, maximum accepted frame bytes excluding FCS.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 rx_dv  input  1  receive byte valid; high for the whole frame including preamble, SFD and FCS.
REQ-007 rx_data  input  8  receive byte.
REQ-008 sfifo_wr  output  1  data FIFO write strobe.
REQ-009 sfifo_din  output  8  data FIFO write byte.
REQ-010 sfifo_commit  output  1  one-cycle pulse; data FIFO publishes bytes written since the last commit or abort.
REQ-011 sfifo_abort  output  1  one-cycle pulse; data FIFO rewinds its write pointer to the last commit.
REQ-012 sfifo_free  input  12  free byte count of the data FIFO.
REQ-013 ptr_sfifo_wr  output  1  pointer FIFO write strobe.
REQ-014 ptr_sfifo_din  output  16  pointer word {1'b0, PORTMAP[3:0], length[10:0]}.
REQ-015 ptr_sfifo_full  input  1  pointer FIFO full.
REQ-016 rx_good, rx_drop  output  1 each  one-cycle status pulses per accepted / discarded frame.

Function
REQ-017 States: IDLE, PREAMBLE, DATA, CHECK, DROP; all outputs registered.
REQ-018 IDLE: rx_dv=1 with 0x55 -> PREAMBLE; rx_dv=1 with 0xD5 -> admission check; any other byte with rx_dv=1 -> DROP.
REQ-019 PREAMBLE: 0x55 stays; 0xD5 -> admission check; other byte -> DROP; rx_dv=0 -> IDLE, no pulses.
REQ-020 Admission on SFD: sfifo_free < MAX_LEN or ptr_sfifo_full=1 -> DROP with rx_drop pulse and zero sfifo writes; else -> DATA, CRC and length cleared.
REQ-021 DATA: every byte feeds CRC-32 (802.3 polynomial, init 0xFFFFFFFF); bytes pass through a 4-byte delay line; from the 5th byte on, the byte leaving the delay line is written (sfifo_wr=1), so the FCS is never written.
REQ-022 Length counter (11 bits) counts written bytes; reaching a write that would exceed MAX_LEN -> that write suppressed, sfifo_abort + rx_drop pulse, -> DROP.
REQ-023 DATA with rx_dv=0 -> CHECK; the delay-line contents are discarded.
REQ-024 CHECK (one cycle): CRC residue == 0xC704DD7B and length >= MIN_LEN -> sfifo_commit, ptr_sfifo_wr, rx_good pulse together; else sfifo_abort and rx_drop pulse.
REQ-025 Commit/abort pulses SHALL appear exactly on the second rising edge after the first edge sampling rx_dv=0.
REQ-026 CHECK exits to PREAMBLE if rx_dv=1 and rx_data=0x55, else IDLE; back-to-back frames with 1-cycle gap are accepted.
REQ-027 DROP: no writes; stays until rx_dv=0, then IDLE.
REQ-028 Exactly one of commit/abort per frame that entered DATA; never both in one cycle; ptr_sfifo_wr never without sfifo_commit.

Reset
REQ-029 rstn low: state IDLE; sfifo_wr, sfifo_commit, sfifo_abort, ptr_sfifo_wr, rx_good, rx_drop = 0; sfifo_din, ptr_sfifo_din = 0; length 0; CRC 0xFFFFFFFF.
REQ-030 Reset mid-frame emits no abort; data FIFO reset is the FIFO owner's responsibility; after release, the remainder of the interrupted frame (no SFD) goes to DROP or IDLE without writes.

Structure
REQ-031 Shared package switch_pkg: PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_RESIDUE 0xC704DD7B, CRC_INIT, pointer field widths/offsets, state encoding.
REQ-032 One sub-module crc32_d8: byte-wide combinational next-CRC with registered state, init/enable inputs.

Verification
REQ-033 Good frame: 7x0x55, 0xD5, 60 payload bytes + correct FCS -> 60 sfifo_wr in order, ptr_sfifo_din=0x083C, one commit, rx_good.
REQ-034 Same frame with one FCS bit flipped -> 60 writes, sfifo_abort, no ptr write, rx_drop.
REQ-035 sfifo_free=1000 at SFD -> zero writes, rx_drop on SFD edge, DROP until rx_dv=0.
REQ-036 Runt of 59 bytes + valid FCS -> abort; 1515-byte frame -> 1514 writes, then abort and DROP.
REQ-037 Two good frames with one idle cycle between -> two commits, two pointer words, no lost bytes.
REQ-038 rstn asserted mid-DATA, released with rx_dv still high -> no writes or pulses until the next valid SFD frame, which commits normally.
